// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b encodings: opcode and ALU-operation enums plus
//                the select encodings of every datapath mux steered by the
//                control FSM.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    // Opcode field IR[15:12], ISA encoding.
    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // ALU operations; alu_pass forwards operand A unchanged.
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    // PC input mux
    localparam logic [1:0] PCMUX_PC_PLUS2     = 2'd0;
    localparam logic [1:0] PCMUX_BR_ADD       = 2'd1;
    localparam logic [1:0] PCMUX_SR1          = 2'd2;
    // Register-file SR1 address mux
    localparam logic       STOREMUX_SR1       = 1'b0;
    localparam logic       STOREMUX_DEST      = 1'b1;
    // ALU operand B mux
    localparam logic [1:0] ALUMUX_SR2         = 2'd0;
    localparam logic [1:0] ALUMUX_ADJ6        = 2'd1;
    localparam logic [1:0] ALUMUX_SEXT5       = 2'd2;
    // Register-file write-data mux
    localparam logic [1:0] REGFILEMUX_ALU     = 2'd0;
    localparam logic [1:0] REGFILEMUX_MDR     = 2'd1;
    localparam logic [1:0] REGFILEMUX_BR_ADD  = 2'd2;
    // MAR input mux
    localparam logic       MARMUX_ALU         = 1'b0;
    localparam logic       MARMUX_PC          = 1'b1;
    // MDR input mux
    localparam logic       MDRMUX_ALU         = 1'b0;
    localparam logic       MDRMUX_MEM         = 1'b1;
    // Only whole-word accesses are issued.
    localparam logic [1:0] MEM_BYTE_EN_WORD   = 2'b11;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/control_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_if
//  Description : Bundle between the control FSM and the datapath/memory.
//                master : the control FSM (drives loads, selects, requests)
//                slave  : datapath + memory side (drives IR fields, mem_resp)
//  Signals     : opcode, imm5_enable, branch_enable, mem_resp (to control);
//                load_*, *mux_sel, aluop, mem_read, mem_write,
//                mem_byte_enable, instr_count (from control)
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_if #(
    parameter int CNT_WIDTH = 16
) ();
    import lc3b_types::*;

    lc3b_opcode             opcode;
    logic                   imm5_enable;
    logic                   branch_enable;
    logic                   mem_resp;

    logic                   load_pc;
    logic                   load_ir;
    logic                   load_regfile;
    logic                   load_mar;
    logic                   load_mdr;
    logic                   load_cc;
    logic [1:0]             pcmux_sel;
    logic                   storemux_sel;
    logic [1:0]             alumux_sel;
    logic [1:0]             regfilemux_sel;
    logic                   marmux_sel;
    logic                   mdrmux_sel;
    lc3b_aluop              aluop;
    logic                   mem_read;
    logic                   mem_write;
    logic [1:0]             mem_byte_enable;
    logic [CNT_WIDTH-1:0]   instr_count;

    modport master (
        input  opcode, imm5_enable, branch_enable, mem_resp,
        output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
               marmux_sel, mdrmux_sel, aluop, mem_read, mem_write,
               mem_byte_enable, instr_count
    );

    modport slave (
        output opcode, imm5_enable, branch_enable, mem_resp,
        input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
               marmux_sel, mdrmux_sel, aluop, mem_read, mem_write,
               mem_byte_enable, instr_count
    );

endinterface : control_if
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// ============================================================================
//  Module      : control
//  Description : Multicycle LC-3b control FSM. Sequences fetch/decode/execute
//                for ADD, AND, NOT, BR, JMP, LDR, STR, LEA; other opcodes
//                retire as NOPs. Outputs are decoded combinationally from the
//                state (and IR fields); instr_count counts retirements.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous, active-high
//                bus   - control_if.master (datapath controls + memory handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    control_if.master bus
);

    typedef enum logic [4:0] {
        S_FETCH1   = 5'd0,
        S_FETCH2   = 5'd1,
        S_FETCH3   = 5'd2,
        S_DECODE   = 5'd3,
        S_ADD      = 5'd4,
        S_AND      = 5'd5,
        S_NOT      = 5'd6,
        S_BR       = 5'd7,
        S_BR_TAKEN = 5'd8,
        S_JMP      = 5'd9,
        S_LEA      = 5'd10,
        S_LDR1     = 5'd11,
        S_LDR2     = 5'd12,
        S_LDR3     = 5'd13,
        S_STR1     = 5'd14,
        S_STR2     = 5'd15,
        S_STR3     = 5'd16
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_retire;       // leaving the final state of an instruction
    logic [CNT_WIDTH-1:0] r_instr_count;

    // ------------------------------------------------------------------
    // Next state and retirement
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        unique case (r_state)
            S_FETCH1: w_next_state = S_FETCH2;
            S_FETCH2: if (bus.mem_resp) w_next_state = S_FETCH3;
            S_FETCH3: w_next_state = S_DECODE;
            S_DECODE: begin
                unique case (bus.opcode)
                    op_add:  w_next_state = S_ADD;
                    op_and:  w_next_state = S_AND;
                    op_not:  w_next_state = S_NOT;
                    op_br:   w_next_state = S_BR;
                    op_jmp:  w_next_state = S_JMP;
                    op_ldr:  w_next_state = S_LDR1;
                    op_str:  w_next_state = S_STR1;
                    op_lea:  w_next_state = S_LEA;
                    default: begin
                        // Unsupported opcode: retire straight from decode.
                        w_next_state = S_FETCH1;
                        w_retire     = 1'b1;
                    end
                endcase
            end
            S_BR: begin
                if (bus.branch_enable) begin
                    w_next_state = S_BR_TAKEN;
                end else begin
                    w_next_state = S_FETCH1;
                    w_retire     = 1'b1;
                end
            end
            S_LDR1: w_next_state = S_LDR2;
            S_LDR2: if (bus.mem_resp) w_next_state = S_LDR3;
            S_STR1: w_next_state = S_STR2;
            S_STR2: w_next_state = S_STR3;
            S_STR3: begin
                if (bus.mem_resp) begin
                    w_next_state = S_FETCH1;
                    w_retire     = 1'b1;
                end
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_LEA, S_LDR3: begin
                w_next_state = S_FETCH1;
                w_retire     = 1'b1;
            end
            default: w_next_state = S_FETCH1;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and retired-instruction counter (wraps naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH1;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.load_pc        = 1'b0;
        bus.load_ir        = 1'b0;
        bus.load_regfile   = 1'b0;
        bus.load_mar       = 1'b0;
        bus.load_mdr       = 1'b0;
        bus.load_cc        = 1'b0;
        bus.pcmux_sel      = PCMUX_PC_PLUS2;
        bus.storemux_sel   = STOREMUX_SR1;
        bus.alumux_sel     = ALUMUX_SR2;
        bus.regfilemux_sel = REGFILEMUX_ALU;
        bus.marmux_sel     = MARMUX_ALU;
        bus.mdrmux_sel     = MDRMUX_ALU;
        bus.aluop          = alu_add;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;

        unique case (r_state)
            S_FETCH1: begin
                bus.marmux_sel = MARMUX_PC;
                bus.load_mar   = 1'b1;
                bus.pcmux_sel  = PCMUX_PC_PLUS2;
                bus.load_pc    = 1'b1;
            end
            // load_mdr every wait cycle so MDR ends up holding the responding data
            S_FETCH2, S_LDR2: begin
                bus.mem_read   = 1'b1;
                bus.mdrmux_sel = MDRMUX_MEM;
                bus.load_mdr   = 1'b1;
            end
            S_FETCH3: bus.load_ir = 1'b1;
            S_ADD, S_AND: begin
                bus.alumux_sel     = bus.imm5_enable ? ALUMUX_SEXT5 : ALUMUX_SR2;
                bus.aluop          = (r_state == S_AND) ? alu_and : alu_add;
                bus.regfilemux_sel = REGFILEMUX_ALU;
                bus.load_regfile   = 1'b1;
                bus.load_cc        = 1'b1;
            end
            S_NOT: begin
                bus.aluop        = alu_not;
                bus.load_regfile = 1'b1;
                bus.load_cc      = 1'b1;
            end
            S_BR_TAKEN: begin
                bus.pcmux_sel = PCMUX_BR_ADD;
                bus.load_pc   = 1'b1;
            end
            S_JMP: begin
                bus.pcmux_sel = PCMUX_SR1;
                bus.load_pc   = 1'b1;
            end
            S_LEA: begin
                bus.regfilemux_sel = REGFILEMUX_BR_ADD;
                bus.load_regfile   = 1'b1;
                bus.load_cc        = 1'b1;
            end
            // Address = base + adj6 for both loads and stores
            S_LDR1, S_STR1: begin
                bus.alumux_sel = ALUMUX_ADJ6;
                bus.aluop      = alu_add;
                bus.marmux_sel = MARMUX_ALU;
                bus.load_mar   = 1'b1;
            end
            S_LDR3: begin
                bus.regfilemux_sel = REGFILEMUX_MDR;
                bus.load_regfile   = 1'b1;
                bus.load_cc        = 1'b1;
            end
            // Store data: SR1 port reads the DEST field and passes through the ALU
            S_STR2: begin
                bus.storemux_sel = STOREMUX_DEST;
                bus.aluop        = alu_pass;
                bus.mdrmux_sel   = MDRMUX_ALU;
                bus.load_mdr     = 1'b1;
            end
            S_STR3: begin
                bus.storemux_sel = STOREMUX_DEST;
                bus.mem_write    = 1'b1;
            end
            default: ;
        endcase

        // Reset parks the FSM in FETCH1; its loads must not fire until release.
        if (reset) begin
            bus.load_pc      = 1'b0;
            bus.load_ir      = 1'b0;
            bus.load_regfile = 1'b0;
            bus.load_mar     = 1'b0;
            bus.load_mdr     = 1'b0;
            bus.load_cc      = 1'b0;
            bus.mem_read     = 1'b0;
            bus.mem_write    = 1'b0;
        end
    end

    assign bus.mem_byte_enable = MEM_BYTE_EN_WORD;
    assign bus.instr_count     = r_instr_count;

endmodule : control
`default_nettype wire
